// File: rtl/i2c_target_pkg.sv
// i2c_target_pkg: shared state encoding and bus direction constants for the
// I2C target register block.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_tgt_state_t;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_pin_filter.sv
// i2c_pin_filter: two-flop synchroniser followed by a stability filter.
// The output only follows the pin after FILT consecutive samples of the new
// level; both stages come out of reset at 1 (idle bus).
module i2c_pin_filter #(
  parameter int FILT = 4
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic pin,
  output logic level
);

  localparam logic [3:0] RELOAD = 4'(FILT - 1);

  logic [1:0] sync;
  logic [3:0] cnt;

  // metastability guard, idle-high
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) sync <= 2'b11;
    else         sync <= {sync[0], pin};
  end

  // down-counter restarts on every sample matching the current level; the
  // level flips when a mismatch is seen with the counter already at zero
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      level <= 1'b1;
      cnt   <= RELOAD;
    end else if (sync[1] == level) begin
      cnt <= RELOAD;
    end else if (cnt == 4'd0) begin
      level <= sync[1];
      cnt   <= RELOAD;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (no clock stretching) in front of a 256 x 8
// register file. Bus writes set an 8-bit pointer, then write auto-incrementing.
// Bus reads exist only when I2C_TARGET_READ_EN is defined; otherwise a read
// address is NACKed.
//
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting in the address byte
//   ADDR_ACK  | 9th clock of a matching address, SDA held low
//   SUB       | shifting in the register pointer byte
//   SUB_ACK   | 9th clock of the pointer byte, SDA held low
//   WDATA     | shifting in a data byte to write at ptr
//   WDATA_ACK | 9th clock of a data byte, SDA held low
//   RDATA     | shifting regs[ptr] out MSB first
//   RDATA_ACK | controller ACK/NACK clock, SDA released
//   IGNORE    | not addressed (or NACKed), wait for START/STOP
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter int         CLK_HZ   = 50_000_000,
  parameter logic [6:0] DEV_ADDR = 7'h39,
  parameter int         FILT     = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  if (FILT < 1 || FILT > 15 || CLK_HZ < 1) begin : g_param_check
    $error("i2c_target_regs: FILT must be 1..15 and CLK_HZ positive");
  end

`ifdef I2C_TARGET_READ_EN
  localparam logic READ_OK = 1'b1;
  logic [7:0] tx_sr;
`else
  localparam logic READ_OK = 1'b0;
`endif

  logic           scl_f, sda_f, scl_q, sda_q, fall_d;
  logic           scl_rise, scl_fall, start_det, stop_det;
  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic [6:0]     shreg;
  logic [7:0]     byte_in;
  logic [7:0]     ptr;
  logic           rw;
  logic           sda_oe;
  logic           addr_hit;
  logic [7:0]     regs [256];

  i2c_pin_filter #(.FILT(FILT)) u_scl_filt (
    .iCLK(iCLK), .iRST_N(iRST_N), .pin(I2C_SCL), .level(scl_f)
  );
  i2c_pin_filter #(.FILT(FILT)) u_sda_filt (
    .iCLK(iCLK), .iRST_N(iRST_N), .pin(I2C_SDA), .level(sda_f)
  );

  assign I2C_SDA   = sda_oe ? 1'b0 : 1'bz;
  assign scl_rise  =  scl_f & ~scl_q;
  assign scl_fall  = ~scl_f &  scl_q;
  assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;
  assign byte_in   = {shreg, sda_f};
  assign addr_hit  = (byte_in[7:1] == DEV_ADDR) && ((byte_in[0] == I2C_WR) || READ_OK);

  // previous filtered levels for edge/condition detection; fall_d delays the
  // SDA drive update by one cycle past the filtered SCL fall
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      fall_d <= 1'b0;
    end else begin
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      fall_d <= scl_fall;
    end
  end

  // register array, written from the registered strobe; host read port sees
  // the pre-write value in the write cycle
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
      rd_data <= 8'h00;
    end else begin
      if (wr_stb) regs[wr_addr] <= wr_data;
      rd_data <= regs[rd_addr];
    end
  end

  // protocol FSM: START/STOP override everything, SDA drive changes only
  // after SCL has fallen, bits are taken on SCL rise
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      ptr     <= 8'h00;
      rw      <= I2C_WR;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
`ifdef I2C_TARGET_READ_EN
      tx_sr   <= 8'h00;
`endif
    end else begin
      wr_stb <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        if (fall_d) begin
          case (state)
            ADDR_ACK, SUB_ACK, WDATA_ACK: sda_oe <= 1'b1;
`ifdef I2C_TARGET_READ_EN
            RDATA:                        sda_oe <= ~tx_sr[7];
`endif
            default:                      sda_oe <= 1'b0;
          endcase
        end
        if (scl_rise) begin
          case (state)
            ADDR: begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= byte_in[0];
                state <= addr_hit ? ADDR_ACK : IGNORE;
              end
            end
            SUB: begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= byte_in;
                state <= SUB_ACK;
              end
            end
            WDATA: begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= byte_in;
                ptr     <= ptr + 8'd1;
                state   <= WDATA_ACK;
              end
            end
            ADDR_ACK: begin
              if (rw == I2C_RD) begin
`ifdef I2C_TARGET_READ_EN
                tx_sr <= regs[ptr];
                state <= RDATA;
`else
                state <= IGNORE;
`endif
              end else begin
                state <= SUB;
              end
            end
            SUB_ACK, WDATA_ACK: state <= WDATA;
`ifdef I2C_TARGET_READ_EN
            RDATA: begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= RDATA_ACK;
            end
            RDATA_ACK: begin
              ptr <= ptr + 8'd1;
              if (!sda_f) begin
                tx_sr <= regs[ptr + 8'd1];
                state <= RDATA;
              end else begin
                state <= IGNORE;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C controller against i2c_target_regs.
// Expected register writes are queued as bytes are driven and matched when
// wr_stb fires; a bench-side register model supplies read-back values.
module tb_i2c_target_regs;
  import i2c_target_pkg::*;

  localparam int T = 20;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda_bus;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data, rd_data;
  logic [7:0] rd_addr = 8'h00;
  logic       busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         stb_cnt = 0;
  int         coll_ph = 0;
  logic [7:0] coll_old, coll_new;
  logic       dut_pull = 1'b0;
  logic [7:0] ptr_m = 8'h00;
  wr_t        exp_q[$];
  logic [7:0] model [256];
  logic [7:0] shadow [256];

  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 iCLK = ~iCLK;

  i2c_target_regs dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .I2C_SCL(scl), .I2C_SDA(sda_bus),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // write-strobe scoreboard, same-cycle read collision, and SDA pull watch
  always @(negedge iCLK) begin
    wr_t e;
    if (coll_ph == 2) begin
      check("rd_coll_new", 32'(rd_data), 32'(coll_new));
      coll_ph = 0;
    end
    if (coll_ph == 1) begin
      check("rd_coll_old", 32'(rd_data), 32'(coll_old));
      coll_ph = 2;
    end
    if (iRST_N && wr_stb) begin
      stb_cnt++;
      check("wr_stb_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
        if (e.a == rd_addr) begin
          coll_old = shadow[e.a];
          coll_new = e.d;
          coll_ph  = 1;
        end
        shadow[e.a] = e.d;
      end
    end
    if (iRST_N && sda_bus === 1'b0 && !sda_low) dut_pull = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; tick(T);
    scl = 1'b1;     tick(T);
    sda_low = 1'b1; tick(T);
    scl = 1'b0;     tick(T);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; tick(T);
    scl = 1'b1;     tick(T);
    sda_low = 1'b0; tick(T);
  endtask

  task automatic clk_bit(input logic drv_low, input logic glitch, output logic smp);
    sda_low = drv_low; tick(T);
    scl = 1'b1; tick(T / 2);
    if (glitch) begin
      scl = 1'b0; tick(2);
      scl = 1'b1; tick(2);
    end
    smp = sda_bus; tick(T);
    scl = 1'b0; tick(T);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(!b[i], glitch_bit == i, s);
    clk_bit(1'b0, 1'b0, s);
    ack = !s;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, 1'b0, s);
      b[i] = s;
    end
    clk_bit(master_ack, 1'b0, s);
  endtask

  task automatic wr_head(input logic [7:0] sub);
    logic ack;
    i2c_start();
    send_byte(8'h72, -1, ack); check("ack_addr", 32'(ack), 1);
    send_byte(sub, -1, ack);   check("ack_sub", 32'(ack), 1);
    ptr_m = sub;
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_bit);
    logic ack;
    wr_t  e;
    e.a = ptr_m; e.d = d;
    exp_q.push_back(e);
    model[ptr_m] = d;
    ptr_m = ptr_m + 8'd1;
    send_byte(d, glitch_bit, ack);
    check("ack_wdata", 32'(ack), 1);
  endtask

  task automatic host_rd(input logic [7:0] a);
    rd_addr = a; tick(2);
    @(negedge iCLK);
    check("rd_data", 32'(rd_data), 32'(model[a]));
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] rb;
    int         stb0;
    for (int i = 0; i < 256; i++) begin model[i] = 8'h00; shadow[i] = 8'h00; end

    // reset values
    tick(3);
    @(negedge iCLK);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_stb", 32'(wr_stb), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_sda", 32'(sda_bus), 1);
    iRST_N = 1'b1;
    tick(10);

    // single write 0x41 = 0x10, host port watching the same index
    rd_addr = 8'h41;
    tick(2);
    wr_head(8'h41);
    @(negedge iCLK);
    check("busy_active", 32'(busy), 1);
    wr_byte(8'h10, -1);
    i2c_stop();
    tick(5);
    @(negedge iCLK);
    check("busy_after_stop", 32'(busy), 0);
    check("sb_empty_1", exp_q.size(), 0);
    host_rd(8'h41);

    // pointer wrap FE -> FF -> 00
    stb0 = stb_cnt;
    wr_head(8'hFE);
    wr_byte(8'hAA, -1);
    wr_byte(8'hBB, -1);
    wr_byte(8'hCC, -1);
    i2c_stop();
    tick(5);
    check("wrap_stb_count", stb_cnt - stb0, 3);
    check("wrap_ptr", 32'(dut.ptr), 32'(ptr_m));
    host_rd(8'hFE);
    host_rd(8'hFF);
    host_rd(8'h00);

    // foreign address: never driven, no strobes
    stb0 = stb_cnt;
    dut_pull = 1'b0;
    i2c_start();
    send_byte(8'h74, -1, ack); check("nack_foreign_addr", 32'(ack), 0);
    send_byte(8'h55, -1, ack); check("nack_foreign_data", 32'(ack), 0);
    i2c_stop();
    tick(5);
    check("foreign_no_pull", 32'(dut_pull), 0);
    check("foreign_no_stb", stb_cnt - stb0, 0);

    // 2-cycle SCL low glitch inside a data bit
    wr_head(8'h20);
    wr_byte(8'h3C, 5);
    i2c_stop();
    tick(5);
    check("sb_empty_glitch", exp_q.size(), 0);
    host_rd(8'h20);

    // read path through repeated START
    wr_head(8'h02);
    wr_byte(8'h5A, -1);
    i2c_stop();
    wr_head(8'h02);
    i2c_start();
    send_byte(8'h73, -1, ack);
`ifdef I2C_TARGET_READ_EN
    check("ack_read_addr", 32'(ack), 1);
    recv_byte(1'b0, rb);
    check("read_byte", 32'(rb), 32'(model[8'h02]));
    i2c_stop();
    tick(5);
    check("read_ptr", 32'(dut.ptr), 3);
`else
    check("nack_read_addr", 32'(ack), 0);
    i2c_stop();
    tick(5);
    check("read_ptr", 32'(dut.ptr), 2);
`endif

    // STOP after 4 data bits
    stb0 = stb_cnt;
    wr_head(8'h10);
    for (int i = 0; i < 4; i++) clk_bit(i[0], 1'b0, s);
    i2c_stop();
    tick(5);
    @(negedge iCLK);
    check("partial_no_stb", stb_cnt - stb0, 0);
    check("partial_state", 32'(dut.state), 32'(IDLE));
    check("partial_busy", 32'(busy), 0);

    // reset pulsed while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) clk_bit(!rb[i] ^ 1'b1 ? 1'b0 : 1'b0, 1'b0, s);
    i2c_stop();
    tick(5);
    i2c_start();
    begin
      logic [7:0] a;
      a = 8'h72;
      for (int i = 7; i >= 0; i--) clk_bit(!a[i], 1'b0, s);
    end
    sda_low = 1'b0;
    tick(T);
    @(negedge iCLK);
    check("ack_state", 32'(dut.state), 32'(ADDR_ACK));
    check("ack_driven", 32'(sda_bus), 0);
    @(posedge iCLK);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("rst_release_sda", 32'(sda_bus), 1);
    tick(2);
    iRST_N = 1'b1;
    for (int i = 0; i < 256; i++) begin model[i] = 8'h00; shadow[i] = 8'h00; end
    ptr_m = 8'h00;
    tick(T);
    dut_pull = 1'b0;
    send_byte(8'h72, -1, ack);
    check("no_start_nack", 32'(ack), 0);
    check("no_start_no_pull", 32'(dut_pull), 0);
    wr_head(8'h05);
    wr_byte(8'h77, -1);
    i2c_stop();
    tick(5);
    for (int i = 0; i < 256; i++) host_rd(8'(i));
    check("sb_empty_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: iCLK frequency, documentation only, with no effect on logic.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h39: 7-bit device address (0x72 write / 0x73 read on the bus).
REQ-003 SHALL have parameter FILT, default 4: number of consecutive iCLK samples a SCL/SDA level must hold to be accepted (1..15).
REQ-004 SHALL have port iCLK, input, 1: system clock; all logic on rising edge.
REQ-005 SHALL have port iRST_N, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port I2C_SCL, input, 1: bus clock; the block is target-only and never stretches SCL.
REQ-007 SHALL have port I2C_SDA, inout, 1: bus data; the block drives only 1'b0 or 1'bz.
REQ-008 SHALL have port wr_stb, output, 1: one-cycle pulse per register write accepted from the bus.
REQ-009 SHALL have port wr_addr, output, 8: register index of the current wr_stb.
REQ-010 SHALL have port wr_data, output, 8: data of the current wr_stb.
REQ-011 SHALL have port rd_addr, input, 8: host-side register read index.
REQ-012 SHALL have port rd_data, output, 8: register contents at rd_addr, registered with 1-cycle latency.
REQ-013 SHALL have port busy, output, 1: high from accepted START to accepted STOP.

Function
REQ-014 SHALL synchronise SCL/SDA through 2 flops, then deglitch each with a FILT-sample stability filter; all decoding uses filtered levels only.
REQ-015 SHALL detect START as a filtered SDA fall while SCL is high, and STOP as a filtered SDA rise while SCL is high.
REQ-016 SHALL sample SDA on the filtered SCL rise and update its SDA drive 1 iCLK after the filtered SCL fall.
REQ-017 SHALL implement the states IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-018 SHALL go from any state to ADDR on START, including a repeated START mid-byte; the bit counter clears and the SDA drive releases.
REQ-019 SHALL go from any state to IDLE on STOP and release SDA; a partially received byte is discarded with no wr_stb.
REQ-020 SHALL, in ADDR, ACK (SDA low for the 9th clock) when address bits [7:1] equal DEV_ADDR; otherwise it goes to IGNORE with SDA released.
REQ-021 SHALL handle an address-match write (R/W=0) as ADDR_ACK -> SUB; the first data byte loads the 8-bit pointer and is ACKed; later bytes go through WDATA.
REQ-022 SHALL, on each WDATA byte, write regs[ptr], pulse wr_stb with wr_addr=ptr and wr_data=byte exactly once (on the 8th SCL rise + 1 cycle), ACK the byte, and increment ptr.
REQ-023 SHALL increment ptr modulo 256 (0xFF -> 0x00); the pointer persists across transactions until reloaded or reset.
REQ-024 SHALL, on a read (R/W=1, see Configuration), present regs[ptr] MSB first in RDATA, sample the controller ACK in RDATA_ACK, increment ptr, continue on ACK, and go to IGNORE on NACK.
REQ-025 SHALL, if a host rd_addr read and a bus write hit the same index in the same cycle, return the old value on rd_data and show the new value one cycle later.

Reset
REQ-026 SHALL, while iRST_N is low, hold state=IDLE, ptr=0, all 256 registers=8'h00, wr_stb=0, wr_addr=0, wr_data=0, rd_data=0, busy=0, filters=1 (idle bus) and SDA=z.
REQ-027 SHALL release SDA immediately on reset asserted mid-transfer and then wait for a new START before responding.

Configuration
REQ-028 SHALL implement read support only when macro I2C_TARGET_READ_EN is defined; RDATA/RDATA_ACK logic and the regs-to-SDA path are then present.
REQ-029 SHALL, when I2C_TARGET_READ_EN is undefined, NACK an address byte with R/W=1 (go to IGNORE) and never enter the RDATA states.

Structure
REQ-030 SHALL put the state enum (i2c_tgt_state_t) and the constants I2C_RD=1'b1 and I2C_WR=1'b0 in package i2c_target_pkg.
REQ-031 SHALL place the synchroniser and stability filter in sub-module i2c_pin_filter, instantiated once each for SCL and SDA.

Verification
REQ-032 SHALL cover this case: START, 0x72, 0x41, 0x10, STOP -> three ACKs, one wr_stb with wr_addr=0x41 and wr_data=0x10; rd_addr=0x41 then gives rd_data=0x10.
REQ-033 SHALL cover this case: START, 0x72, 0xFE, 0xAA, 0xBB, 0xCC, STOP -> regs FE=AA, FF=BB, 00=CC, with exactly 3 wr_stb pulses.
REQ-034 SHALL cover this case: START, 0x74, 0x55, STOP -> SDA never driven low and no wr_stb.
REQ-035 SHALL cover this case, with READ_EN: write 0x02=0x5A, then START, 0x72, 0x02, Sr, 0x73, read with NACK -> bus returns 0x5A and ptr=0x03; without READ_EN, 0x73 is NACKed.
REQ-036 SHALL cover this case: STOP after 4 bits of a data byte -> no wr_stb, state IDLE; iRST_N pulsed during ADDR_ACK -> SDA=z within 1 cycle and all regs=0.
REQ-037 SHALL cover this case: a 2-cycle SCL low glitch with FILT=4 during WDATA -> ignored, and the byte is still written correctly.
